// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: shares one registered write port between CPU writes
// and a rectangle-fill engine. Optional fill abort input enabled by FB_FILL_ABORT_EN.
`ifndef FB_ADDR_WIDTH
`define FB_ADDR_WIDTH 16
`endif

module fb_write_scheduler #(
   parameter int ADDR_W    = `FB_ADDR_WIDTH,
   parameter int DIM_W     = 12,
   parameter int CPU_BURST = 4
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic              i_cpu_req,
   input  logic [ADDR_W-1:0] i_cpu_offset,
   input  logic [31:0]       i_cpu_wdata,
   output logic              o_cpu_ack,
`ifdef FB_FILL_ABORT_EN
   input  logic              i_fill_abort,
`endif
   input  logic              i_fill_start,
   input  logic [ADDR_W-1:0] i_fill_base,
   input  logic [DIM_W-1:0]  i_fill_width,
   input  logic [DIM_W-1:0]  i_fill_height,
   input  logic [DIM_W-1:0]  i_fill_stride,
   input  logic [31:0]       i_fill_data,
   output logic [ADDR_W-1:0] o_fb_offset,
   output logic              o_fb_we,
   output logic [31:0]       o_fb_wdata,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BW = $clog2(CPU_BURST + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DIM_W-1:0]  col_q, col_d;
   logic [DIM_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic [DIM_W-1:0]  stride_q, stride_d;
   logic [31:0]       data_q, data_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic [ADDR_W-1:0] fb_offset_q, fb_offset_d;
   logic              fb_we_q, fb_we_d;
   logic [31:0]       fb_wdata_q, fb_wdata_d;
   logic              done_q, done_d;

   logic              abort;
   logic              fill_pend;
   logic              cpu_grant;
   logic              fill_grant;
   logic              last_word;
   logic [ADDR_W-1:0] fill_addr;

`ifdef FB_FILL_ABORT_EN
   assign abort = i_fill_abort;
`else
   assign abort = 1'b0;
`endif

   // An abort withdraws the fill from arbitration in the same cycle it is seen.
   assign fill_pend  = (state_q == FILL) && !abort;
   assign cpu_grant  = i_cpu_req && !(fill_pend && (burst_q == BW'(CPU_BURST)));
   assign fill_grant = fill_pend && !cpu_grant;
   assign last_word  = (col_q == width_q - DIM_W'(1)) && (row_q == height_q - DIM_W'(1));
   assign fill_addr  = row_base_q + ADDR_W'(col_q);

   // NOTE: every always_comb target gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      row_base_d  = row_base_q;
      width_d     = width_q;
      height_d    = height_q;
      stride_d    = stride_q;
      data_d      = data_q;
      burst_d     = '0;
      fb_offset_d = fb_offset_q;
      fb_we_d     = cpu_grant || fill_grant;
      fb_wdata_d  = fb_wdata_q;
      done_d      = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (i_fill_start) begin
               width_d    = i_fill_width;
               height_d   = i_fill_height;
               stride_d   = i_fill_stride;
               data_d     = i_fill_data;
               row_base_d = i_fill_base;
               col_d      = '0;
               row_d      = '0;
               state_d    = (i_fill_width != '0 && i_fill_height != '0) ? FILL : DONE;
            end
         end
         FILL: begin
            if (abort || (fill_grant && last_word)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      if (cpu_grant) begin
         fb_offset_d = i_cpu_offset;
         fb_wdata_d  = i_cpu_wdata;
         if (fill_pend) burst_d = burst_q + BW'(1);
      end else if (fill_grant) begin
         fb_offset_d = fill_addr;
         fb_wdata_d  = data_q;
         if (col_q != width_q - DIM_W'(1)) begin
            col_d = col_q + DIM_W'(1);
         end else begin
            col_d      = '0;
            row_d      = row_q + DIM_W'(1);
            row_base_d = row_base_q + ADDR_W'(stride_q);
         end
      end
   end

   // NOTE: state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         row_base_q  <= '0;
         width_q     <= '0;
         height_q    <= '0;
         stride_q    <= '0;
         data_q      <= '0;
         burst_q     <= '0;
         fb_offset_q <= '0;
         fb_we_q     <= 1'b0;
         fb_wdata_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         row_base_q  <= row_base_d;
         width_q     <= width_d;
         height_q    <= height_d;
         stride_q    <= stride_d;
         data_q      <= data_d;
         burst_q     <= burst_d;
         fb_offset_q <= fb_offset_d;
         fb_we_q     <= fb_we_d;
         fb_wdata_q  <= fb_wdata_d;
         done_q      <= done_d;
      end
   end

   assign o_cpu_ack   = cpu_grant;
   assign o_fb_offset = fb_offset_q;
   assign o_fb_we     = fb_we_q;
   assign o_fb_wdata  = fb_wdata_q;
   assign o_busy      = (state_q != IDLE);
   assign o_done      = done_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed self-checking bench for fb_write_scheduler (ADDR_W=12, CPU_BURST=4).
// Exercises the abort input only when FB_FILL_ABORT_EN is defined.
module tb_fb_write_scheduler;

   localparam int ADDR_W = 12;
   localparam int DIM_W  = 12;

   logic              CLK;
   logic              RST_X;
   logic              i_cpu_req;
   logic [ADDR_W-1:0] i_cpu_offset;
   logic [31:0]       i_cpu_wdata;
   logic              o_cpu_ack;
   logic              i_fill_abort;
   logic              i_fill_start;
   logic [ADDR_W-1:0] i_fill_base;
   logic [DIM_W-1:0]  i_fill_width;
   logic [DIM_W-1:0]  i_fill_height;
   logic [DIM_W-1:0]  i_fill_stride;
   logic [31:0]       i_fill_data;
   logic [ADDR_W-1:0] o_fb_offset;
   logic              o_fb_we;
   logic [31:0]       o_fb_wdata;
   logic              o_busy;
   logic              o_done;

   int vectors     = 0;
   int miscompares = 0;

   fb_write_scheduler #(
      .ADDR_W   (ADDR_W),
      .DIM_W    (DIM_W),
      .CPU_BURST(4)
   ) dut (
      .CLK          (CLK),
      .RST_X        (RST_X),
      .i_cpu_req    (i_cpu_req),
      .i_cpu_offset (i_cpu_offset),
      .i_cpu_wdata  (i_cpu_wdata),
      .o_cpu_ack    (o_cpu_ack),
`ifdef FB_FILL_ABORT_EN
      .i_fill_abort (i_fill_abort),
`endif
      .i_fill_start (i_fill_start),
      .i_fill_base  (i_fill_base),
      .i_fill_width (i_fill_width),
      .i_fill_height(i_fill_height),
      .i_fill_stride(i_fill_stride),
      .i_fill_data  (i_fill_data),
      .o_fb_offset  (o_fb_offset),
      .o_fb_we      (o_fb_we),
      .o_fb_wdata   (o_fb_wdata),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_fill(input logic [ADDR_W-1:0] base, input logic [DIM_W-1:0] w,
                             input logic [DIM_W-1:0] h, input logic [DIM_W-1:0] s,
                             input logic [31:0] d);
      i_fill_start  = 1'b1;
      i_fill_base   = base;
      i_fill_width  = w;
      i_fill_height = h;
      i_fill_stride = s;
      i_fill_data   = d;
      tick();
      i_fill_start  = 1'b0;
   endtask

   logic [ADDR_W-1:0] exp_off [6];
   int                fill_idx;

   initial begin
      RST_X = 1'b0; i_cpu_req = 1'b0; i_cpu_offset = '0; i_cpu_wdata = '0;
      i_fill_abort = 1'b0; i_fill_start = 1'b0; i_fill_base = '0; i_fill_width = '0;
      i_fill_height = '0; i_fill_stride = '0; i_fill_data = '0;
      tick();
      tick();
      check("rst_we",     o_fb_we,     0);
      check("rst_offset", o_fb_offset, 0);
      check("rst_wdata",  o_fb_wdata,  0);
      check("rst_busy",   o_busy,      0);
      check("rst_done",   o_done,      0);
      RST_X = 1'b1;
      tick();

      // CPU only: three back-to-back acked writes
      for (int i = 0; i < 3; i++) begin
         i_cpu_req    = 1'b1;
         i_cpu_offset = ADDR_W'(12'h010 + i);
         i_cpu_wdata  = 32'hA5A5_0001 + i;
         #1;
         check("cpu_ack", o_cpu_ack, 1);
         check("cpu_busy", o_busy, 0);
         tick();
         check("cpu_we",     o_fb_we,     1);
         check("cpu_offset", o_fb_offset, 12'h010 + i);
         check("cpu_wdata",  o_fb_wdata,  32'hA5A5_0001 + i);
      end
      i_cpu_req = 1'b0;
      tick();
      check("cpu_idle_we",   o_fb_we,     0);
      check("cpu_hold_off",  o_fb_offset, 12'h012);
      check("cpu_hold_data", o_fb_wdata,  32'hA5A5_0003);

      // Fill alone: 3x2 words, stride 80
      exp_off = '{12'h100, 12'h101, 12'h102, 12'h150, 12'h151, 12'h152};
      start_fill(12'h100, 12'd3, 12'd2, 12'd80, 32'hF800_F800);
      check("fill_busy", o_busy, 1);
      check("fill_first_we", o_fb_we, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("fill_we",     o_fb_we,     1);
         check("fill_offset", o_fb_offset, exp_off[k]);
         check("fill_wdata",  o_fb_wdata,  32'hF800_F800);
      end
      check("fill_busy_last", o_busy, 1);
      check("fill_done_early", o_done, 0);
      tick();
      check("fill_done", o_done, 1);
      check("fill_busy_fall", o_busy, 0);
      check("fill_post_we", o_fb_we, 0);
      tick();
      check("fill_done_pulse", o_done, 0);

      // Contention: 4-word fill vs continuous CPU requests -> CPU x4, fill x1
      start_fill(12'h200, 12'd4, 12'd1, 12'd0, 32'h1234_5678);
      i_cpu_req    = 1'b1;
      i_cpu_offset = 12'h3C0;
      fill_idx     = 0;
      for (int i = 0; i < 20; i++) begin
         i_cpu_wdata = 32'hC0DE_0000 + i;
         #1;
         check("arb_ack", o_cpu_ack, (i % 5 == 4) ? 0 : 1);
         tick();
         check("arb_we", o_fb_we, 1);
         if (i % 5 == 4) begin
            check("arb_fill_off",  o_fb_offset, 12'h200 + fill_idx);
            check("arb_fill_data", o_fb_wdata,  32'h1234_5678);
            fill_idx++;
         end else begin
            check("arb_cpu_off",  o_fb_offset, 12'h3C0);
            check("arb_cpu_data", o_fb_wdata,  32'hC0DE_0000 + i);
         end
      end
      check("arb_busy", o_busy, 1);
      i_cpu_req = 1'b0;
      tick();
      check("arb_done", o_done, 1);
      check("arb_busy_fall", o_busy, 0);
      tick();
      check("arb_done_pulse", o_done, 0);

      // Zero-size fill, with a second start while busy
      start_fill(12'h080, 12'd0, 12'd5, 12'd1, 32'hDEAD_BEEF);
      check("zero_busy", o_busy, 1);
      check("zero_we", o_fb_we, 0);
      i_fill_start = 1'b1; i_fill_width = 12'd3; i_fill_height = 12'd3;
      tick();
      i_fill_start = 1'b0;
      check("zero_done", o_done, 1);
      check("zero_we2", o_fb_we, 0);
      tick();
      check("zero_done_pulse", o_done, 0);
      check("zero_no_refill", o_busy, 0);
      check("zero_we3", o_fb_we, 0);

      // Address wrap at 2^ADDR_W; start during FILL is ignored
      exp_off[0:3] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      start_fill(12'hFFE, 12'd4, 12'd1, 12'd0, 32'h0000_07E0);
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin
            i_fill_start = 1'b1; i_fill_base = 12'h555; i_fill_data = 32'h1111_1111;
         end
         tick();
         i_fill_start = 1'b0;
         check("wrap_we",     o_fb_we,     1);
         check("wrap_offset", o_fb_offset, exp_off[k]);
         check("wrap_wdata",  o_fb_wdata,  32'h0000_07E0);
      end
      tick();
      check("wrap_done", o_done, 1);
      tick();

      // Reset mid-fill after two writes
      start_fill(12'h040, 12'd3, 12'd2, 12'd3, 32'hAAAA_5555);
      tick();
      check("rstfill_w0", o_fb_offset, 12'h040);
      tick();
      check("rstfill_w1", o_fb_offset, 12'h041);
      RST_X = 1'b0;
      tick();
      RST_X = 1'b1;
      check("rstfill_we",    o_fb_we,     0);
      check("rstfill_off",   o_fb_offset, 0);
      check("rstfill_wdata", o_fb_wdata,  0);
      check("rstfill_busy",  o_busy,      0);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rstfill_quiet", {o_fb_we, o_done, o_busy}, 3'b000);
      end

`ifdef FB_FILL_ABORT_EN
      // Abort after two writes: no more fill writes, then o_done
      start_fill(12'h020, 12'd6, 12'd1, 12'd0, 32'h0F0F_0F0F);
      tick();
      check("abort_w0", o_fb_offset, 12'h020);
      tick();
      check("abort_w1", o_fb_offset, 12'h021);
      i_fill_abort = 1'b1;
      tick();
      i_fill_abort = 1'b0;
      check("abort_we",   o_fb_we, 0);
      check("abort_busy", o_busy,  1);
      tick();
      check("abort_done", o_done,  1);
      check("abort_we2",  o_fb_we, 0);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sequences and shares the single framebuffer write port between two requesters: the CPU/MMIO path and a built-in rectangle-fill engine.
- Sits between the bus-side peripheral decode and the framebuffer peripheral's write inputs (offset / we / 32-bit wdata, two RGB565 pixels per word).
- Drives that port with registered outputs.
- The fill engine writes a constant 32-bit word over a width × height rectangle of words, with an arbitrary row stride.

Parameters:
- ADDR_W, `FB_ADDR_WIDTH, framebuffer word-offset width
- DIM_W, 12, width of the rectangle width/height/stride fields
- CPU_BURST, 4, max consecutive CPU grants while a fill is pending before the fill engine is given one slot (≥1)

Ports:
- CLK  in  1  system clock
- RST_X  in  1  synchronous active-low reset
- i_cpu_req  in  1  CPU write request; held until acked
- i_cpu_offset  in  ADDR_W  CPU write word offset
- i_cpu_wdata  in  32  CPU write data
- o_cpu_ack  out  1  combinational grant; request consumed this cycle
- i_fill_start  in  1  one-cycle pulse; latches fill config
- i_fill_base  in  ADDR_W  first word offset of rectangle
- i_fill_width  in  DIM_W  words per row
- i_fill_height  in  DIM_W  rows
- i_fill_stride  in  DIM_W  word distance between row starts
- i_fill_data  in  32  fill word
- o_fb_offset  out  ADDR_W  to framebuffer write offset
- o_fb_we  out  1  to framebuffer write enable
- o_fb_wdata  out  32  to framebuffer write data
- o_busy  out  1  fill in progress
- o_done  out  1  one-cycle pulse at fill completion

Behaviour:
- Reset (RST_X=0 at CLK edge): all outputs 0, FSM=IDLE, counters/config cleared, CPU burst counter 0. Reset mid-fill abandons the fill with no further writes and no o_done.
- FSM: IDLE, FILL, DONE.
  - IDLE→FILL on i_fill_start with width≠0 and height≠0. Latches base, width, height, stride, data; col=0, row=0, row_base=base.
  - IDLE→DONE on i_fill_start with width=0 or height=0 (zero writes).
  - FILL→DONE after the fill slot writing col=width-1, row=height-1.
  - DONE→IDLE unconditionally. o_done=1 in the cycle after DONE is entered (registered), for exactly 1 cycle.
- o_busy=1 in FILL and DONE, else 0.
- i_fill_start outside IDLE is ignored; config is not changed.
- Arbitration (evaluated every cycle):
  - Fill is pending when in FILL.
  - If i_cpu_req and not (fill pending and burst_cnt==CPU_BURST): grant CPU, o_cpu_ack=1, burst_cnt+=1 if fill pending.
  - Else if fill pending: grant fill, burst_cnt=0.
  - burst_cnt resets to 0 whenever fill is not pending.
  - With no fill, the CPU is granted every cycle it requests; back-to-back acks are allowed.
- Write port latency: a grant in cycle N gives o_fb_we=1 with the granted offset/data in cycle N+1. With no grant, o_fb_we=0 in N+1; offset/wdata hold their last value.
- Fill address: o_fb_offset = row_base + col, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
- Fill counter advance, on each fill grant:
  - If col<width-1: col+=1.
  - Otherwise: col=0, row+=1, row_base+=stride (zero-extended, modulo 2^ADDR_W).
- stride<width is legal; rows then overlap and the later row overwrites.
- A CPU write and the fill are never emitted in the same cycle; the write port has exactly one source per cycle.

Optional Feature:
- Macro: FB_FILL_ABORT_EN.
- With the macro: adds input i_fill_abort (1 bit).
  - i_fill_abort=1 in FILL → next state DONE, no further fill grants from that cycle on. A write already granted in the previous cycle still appears.
  - o_done pulses as normal.
  - In IDLE or DONE the abort is ignored.
  - Abort and start in the same IDLE cycle: the start wins.
- Without the macro: the port is absent and a fill always runs to completion.

Test Plan:
- CPU only: req held 3 cycles, offsets 0x10/0x11/0x12, data 0xA5A5_0001..3 → ack in each cycle; o_fb_we=1 on the following 3 cycles with matching offset/data; o_busy=0 throughout.
- Fill alone: base=0x100, width=3, height=2, stride=80, data=0xF800_F800 → 6 writes on consecutive cycles at offsets 0x100,0x101,0x102,0x150,0x151,0x152; then o_done=1 for 1 cycle; o_busy falls with it.
- Contention: CPU_BURST=4, fill of 4 words with CPU req held high throughout → pattern of 4 CPU writes, 1 fill write, repeated. All 4 fill writes land; o_done follows the 4th fill write.
- Zero size: start with width=0, height=5 → no o_fb_we; o_done pulses 2 cycles after start; start pulse during busy ignored (config unchanged, single o_done).
- Wrap: ADDR_W=8, base=0xFE, width=4, height=1 → offsets 0xFE,0xFF,0x00,0x01.
- Reset mid-fill: RST_X=0 for 1 cycle after 2 of 6 fill writes → all outputs 0 next cycle, no further writes, no o_done. With FB_FILL_ABORT_EN, abort after 2 writes → at most 1 more write, then o_done.
